// File: rtl/ext_mem_sequencer.sv
// Command-driven sequencer for the multicore processor's external access pins:
// loads IRAM/DRAM from a word stream, runs the processor, and streams a DRAM window back.
module ext_mem_sequencer #(
    parameter int NUM_CORES = 2,
    parameter int ADDR_W    = 9,
    parameter int DATA_W    = 16,
    parameter int WR_PULSE  = 4,
    parameter int RD_LAT    = 5,
    parameter int RUN_MAX   = 120000,
    parameter int CORE_W    = (NUM_CORES > 1) ? $clog2(NUM_CORES) : 1
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic                 cmd_valid,
    output logic                 cmd_ready,
    input  logic [1:0]           cmd_op,
    input  logic [CORE_W-1:0]    cmd_core,
    input  logic [ADDR_W-1:0]    cmd_base,
    input  logic [ADDR_W:0]      cmd_count,
    input  logic                 wr_valid,
    output logic                 wr_ready,
    input  logic [DATA_W-1:0]    wr_data,
    output logic                 rd_valid,
    input  logic                 rd_ready,
    output logic [DATA_W-1:0]    rd_data,
    output logic [ADDR_W-1:0]    addr_ext,
    output logic [DATA_W-1:0]    data_out,
    output logic [NUM_CORES-1:0] iram_write_ext,
    output logic                 dram_write_ext,
    output logic                 read_en_ext,
    input  logic [DATA_W-1:0]    dram_in,
    output logic                 start,
    output logic                 start_2,
    output logic                 start_3,
    output logic                 start_4,
    input  logic                 proc_done,
    output logic                 done,
    output logic                 err_core,
    output logic                 timeout
);

    typedef enum logic [2:0] {
        IDLE, LD_WAIT, LD_SETUP, LD_STROBE, LD_HOLD, RUN, RB_REQ, RB_OUT
    } state_t;

    localparam logic [1:0] OP_IRAM = 2'd0;
    localparam logic [1:0] OP_DRAM = 2'd1;
    localparam logic [1:0] OP_RUN  = 2'd2;
    localparam logic [1:0] OP_RB   = 2'd3;

    state_t                state;
    logic                  is_dram;
    logic [CORE_W-1:0]     core_q;
    logic [ADDR_W:0]       remaining;
    logic [31:0]           cnt;
    logic [NUM_CORES-1:0]  core_onehot;
    logic                  core_bad;

    for (genvar g = 0; g < NUM_CORES; g++) begin : g_core_sel
        assign core_onehot[g] = (core_q == CORE_W'(g));
    end

    assign core_bad  = (32'(cmd_core) >= NUM_CORES);
    assign cmd_ready = (state == IDLE);
    assign wr_ready  = (state == LD_WAIT);

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state          <= IDLE;
            is_dram        <= 1'b0;
            core_q         <= '0;
            remaining      <= '0;
            cnt            <= '0;
            addr_ext       <= '0;
            data_out       <= '0;
            iram_write_ext <= '0;
            dram_write_ext <= 1'b0;
            read_en_ext    <= 1'b0;
            rd_valid       <= 1'b0;
            rd_data        <= '0;
            start          <= 1'b0;
            start_2        <= 1'b0;
            start_3        <= 1'b0;
            start_4        <= 1'b0;
            done           <= 1'b0;
            err_core       <= 1'b0;
            timeout        <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (cmd_valid) begin
                        err_core  <= 1'b0;
                        timeout   <= 1'b0;
                        addr_ext  <= cmd_base;
                        remaining <= cmd_count;
                        core_q    <= cmd_core;
                        is_dram   <= (cmd_op == OP_DRAM);
                        cnt       <= '0;
                        case (cmd_op)
                            OP_IRAM, OP_DRAM: begin
                                // Bad core or empty load finishes at once without touching any pin
                                if (cmd_op == OP_IRAM && core_bad) begin
                                    err_core <= 1'b1;
                                    done     <= 1'b1;
                                end else if (cmd_count == '0) begin
                                    done <= 1'b1;
                                end else begin
                                    start_2 <= (cmd_op == OP_IRAM);
                                    start_3 <= (cmd_op == OP_DRAM);
                                    state   <= LD_WAIT;
                                end
                            end
                            OP_RUN: begin
                                start <= 1'b1;
                                state <= RUN;
                            end
                            OP_RB: begin
                                if (cmd_count == '0) begin
                                    done <= 1'b1;
                                end else begin
                                    start_4     <= 1'b1;
                                    read_en_ext <= 1'b1;
                                    state       <= RB_REQ;
                                end
                            end
                            default: state <= IDLE;
                        endcase
                    end
                end
                LD_WAIT: begin
                    if (wr_valid) begin
                        data_out <= wr_data;
                        state    <= LD_SETUP;
                    end
                end
                LD_SETUP: begin
                    cnt <= '0;
                    if (is_dram) dram_write_ext <= 1'b1;
                    else         iram_write_ext <= core_onehot;
                    state <= LD_STROBE;
                end
                LD_STROBE: begin
                    if (cnt == 32'(WR_PULSE - 1)) begin
                        iram_write_ext <= '0;
                        dram_write_ext <= 1'b0;
                        state          <= LD_HOLD;
                    end else begin
                        cnt <= cnt + 32'd1;
                    end
                end
                LD_HOLD: begin
                    addr_ext  <= addr_ext + 1'b1;
                    remaining <= remaining - 1'b1;
                    if (remaining == (ADDR_W+1)'(1)) begin
                        start_2 <= 1'b0;
                        start_3 <= 1'b0;
                        done    <= 1'b1;
                        state   <= IDLE;
                    end else begin
                        state <= LD_WAIT;
                    end
                end
                RUN: begin
                    if (proc_done) begin
                        start <= 1'b0;
                        done  <= 1'b1;
                        state <= IDLE;
                    end else if (cnt == 32'(RUN_MAX - 1)) begin
                        start   <= 1'b0;
                        timeout <= 1'b1;
                        done    <= 1'b1;
                        state   <= IDLE;
                    end else begin
                        cnt <= cnt + 32'd1;
                    end
                end
                RB_REQ: begin
                    // dram_in is taken at the close of the final read_en_ext cycle
                    if (cnt == 32'(RD_LAT - 1)) begin
                        rd_data     <= dram_in;
                        read_en_ext <= 1'b0;
                        rd_valid    <= 1'b1;
                        state       <= RB_OUT;
                    end else begin
                        cnt <= cnt + 32'd1;
                    end
                end
                RB_OUT: begin
                    if (rd_ready) begin
                        rd_valid  <= 1'b0;
                        addr_ext  <= addr_ext + 1'b1;
                        remaining <= remaining - 1'b1;
                        if (remaining == (ADDR_W+1)'(1)) begin
                            start_4 <= 1'b0;
                            done    <= 1'b1;
                            state   <= IDLE;
                        end else begin
                            read_en_ext <= 1'b1;
                            cnt         <= '0;
                            state       <= RB_REQ;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_ext_mem_sequencer.sv
// Directed bench for ext_mem_sequencer: expected write/read transactions are queued by the
// stimulus and matched against observed strobe runs by a cycle monitor.
module tb_ext_mem_sequencer;

    localparam int NC = 3;
    localparam int AW = 9;
    localparam int DW = 16;
    localparam int WP = 4;
    localparam int RL = 5;
    localparam int RM = 100;
    localparam int CW = 2;

    logic          clock = 1'b0;
    logic          reset = 1'b1;
    logic          cmd_valid = 1'b0;
    logic          cmd_ready;
    logic [1:0]    cmd_op = '0;
    logic [CW-1:0] cmd_core = '0;
    logic [AW-1:0] cmd_base = '0;
    logic [AW:0]   cmd_count = '0;
    logic          wr_valid = 1'b0;
    logic          wr_ready;
    logic [DW-1:0] wr_data = '0;
    logic          rd_valid;
    logic          rd_ready = 1'b0;
    logic [DW-1:0] rd_data;
    logic [AW-1:0] addr_ext;
    logic [DW-1:0] data_out;
    logic [NC-1:0] iram_write_ext;
    logic          dram_write_ext;
    logic          read_en_ext;
    logic [DW-1:0] dram_in;
    logic          start, start_2, start_3, start_4;
    logic          proc_done = 1'b0;
    logic          done, err_core, timeout;

    ext_mem_sequencer #(
        .NUM_CORES(NC), .ADDR_W(AW), .DATA_W(DW),
        .WR_PULSE(WP), .RD_LAT(RL), .RUN_MAX(RM)
    ) dut (
        .clock(clock), .reset(reset),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
        .cmd_core(cmd_core), .cmd_base(cmd_base), .cmd_count(cmd_count),
        .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_data(wr_data),
        .rd_valid(rd_valid), .rd_ready(rd_ready), .rd_data(rd_data),
        .addr_ext(addr_ext), .data_out(data_out),
        .iram_write_ext(iram_write_ext), .dram_write_ext(dram_write_ext),
        .read_en_ext(read_en_ext), .dram_in(dram_in),
        .start(start), .start_2(start_2), .start_3(start_3), .start_4(start_4),
        .proc_done(proc_done), .done(done), .err_core(err_core), .timeout(timeout)
    );

    always #5 clock = ~clock;

    // DRAM stand-in: every location holds three times its address
    assign dram_in = DW'(32'(addr_ext) * 3);

    int checks = 0;
    int errors = 0;

    task automatic chk_eq(input string nm, input longint act, input longint exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
        end
    endtask

    // Model state and observation logs
    int  wq_addr[$], wq_data[$], wq_vec[$];
    int  wlog_addr[$], wlog_data[$], wlog_vec[$];
    int  rq[$], rlog[$];
    bit  in_w, in_r, busy, p_ready, p_rd_valid, p_done;
    int  w_len, r_len, s_len, start_len;
    int  done_cnt, strobe_cycles, mode_cycles, rd_en_cycles;
    int  w_addr, w_data, w_vec;
    logic [DW-1:0] p_rd_data;

    initial forever begin
        @(posedge clock);
        #1;
        if (reset) begin
            in_w = 0; in_r = 0; busy = 0; p_ready = 0; p_rd_valid = 0; p_done = 0;
            s_len = 0; p_rd_data = '0;
        end else begin
            chk_eq("mode_excl", $onehot0({start, start_2, start_3, start_4}), 1);
            chk_eq("strobe_excl", $onehot0({iram_write_ext, dram_write_ext, read_en_ext}), 1);
            chk_eq("rd_valid_outside_rb", rd_valid && !start_4, 0);

            if (cmd_valid && p_ready) busy = 1;
            if (done) begin
                done_cnt++;
                chk_eq("done_single_cycle", p_done, 0);
                busy = 0;
            end
            chk_eq("cmd_ready", cmd_ready, !busy);

            if ({dram_write_ext, iram_write_ext} != 0) begin
                strobe_cycles++;
                chk_eq("strobe_mode_pin", dram_write_ext ? start_3 : start_2, 1);
                if (!in_w) begin
                    in_w = 1; w_len = 1;
                    w_addr = int'(addr_ext); w_data = int'(data_out);
                    w_vec = int'({dram_write_ext, iram_write_ext});
                end else begin
                    w_len++;
                    chk_eq("strobe_addr_stable", addr_ext, w_addr);
                    chk_eq("strobe_data_stable", data_out, w_data);
                    chk_eq("strobe_vec_stable", {dram_write_ext, iram_write_ext}, w_vec);
                end
            end else if (in_w) begin
                in_w = 0;
                chk_eq("strobe_len", w_len, WP);
                if (wq_addr.size() == 0) begin
                    chk_eq("unexpected_write_addr", w_addr, -1);
                end else begin
                    chk_eq("write_addr", w_addr, wq_addr.pop_front());
                    chk_eq("write_data", w_data, wq_data.pop_front());
                    chk_eq("write_target", w_vec, wq_vec.pop_front());
                end
                wlog_addr.push_back(w_addr);
                wlog_data.push_back(w_data);
                wlog_vec.push_back(w_vec);
            end

            if (read_en_ext) begin
                rd_en_cycles++;
                chk_eq("read_en_mode_pin", start_4, 1);
                if (!in_r) begin in_r = 1; r_len = 1; end
                else r_len++;
            end else if (in_r) begin
                in_r = 0;
                chk_eq("read_en_len", r_len, RL);
            end

            if (p_rd_valid && rd_ready) rlog.push_back(int'(p_rd_data));
            if (rd_valid) begin
                if (p_rd_valid && !rd_ready) begin
                    chk_eq("rd_data_stable", rd_data, p_rd_data);
                end else if (rq.size() == 0) begin
                    chk_eq("unexpected_rd_data", rd_data, -1);
                end else begin
                    chk_eq("rd_data", rd_data, rq.pop_front());
                end
            end

            if (start) s_len++;
            else if (s_len != 0) begin start_len = s_len; s_len = 0; end
            if (start || start_2 || start_3 || start_4) mode_cycles++;

            p_ready = cmd_ready; p_rd_valid = rd_valid; p_rd_data = rd_data; p_done = done;
        end
    end

    task automatic send_cmd(input logic [1:0] op, input int core, input int base, input int count);
        int n;
        n = 0;
        @(negedge clock);
        cmd_op = op; cmd_core = CW'(core); cmd_base = AW'(base); cmd_count = (AW+1)'(count);
        cmd_valid = 1'b1;
        while (!cmd_ready && n < 50) begin @(negedge clock); n++; end
        chk_eq("cmd_accept", cmd_ready, 1);
        @(negedge clock);
        cmd_valid = 1'b0;
    endtask

    task automatic wait_done(input string nm, input int budget);
        int n;
        n = 0;
        while (!done && n < budget) begin @(negedge clock); n++; end
        chk_eq({nm, "_done"}, done, 1);
    endtask

    task automatic do_load(input logic [1:0] op, input int core, input int base, input int count,
                           input int w0, input int w1, input int w2);
        int w[3];
        int d0, n;
        w[0] = w0; w[1] = w1; w[2] = w2;
        d0 = done_cnt;
        for (int i = 0; i < count; i++) begin
            wq_addr.push_back((base + i) % (1 << AW));
            wq_data.push_back(w[i]);
            wq_vec.push_back(op == 2'd1 ? 8 : (1 << core));
        end
        send_cmd(op, core, base, count);
        for (int i = 0; i < count; i++) begin
            n = 0;
            while (!wr_ready && n < 50) begin @(negedge clock); n++; end
            chk_eq("wr_ready_wait", wr_ready, 1);
            wr_valid = 1'b1; wr_data = DW'(w[i]);
            @(negedge clock);
            wr_valid = 1'b0;
        end
        wait_done("load", 100);
        chk_eq("load_done_count", done_cnt - d0, 1);
        chk_eq("load_queue_empty", wq_addr.size(), 0);
    endtask

    task automatic run_cmd(input int done_at, input int exp_len, input bit exp_to);
        int c, it;
        c = 0; it = 0;
        send_cmd(2'd2, 0, 0, 0);
        if (done_at > 0) begin
            while (it < 300) begin
                if (start) c++;
                if (c == done_at) begin
                    proc_done = 1'b1;
                    @(negedge clock);
                    proc_done = 1'b0;
                    break;
                end
                @(negedge clock);
                it++;
            end
        end
        wait_done("run", 300);
        chk_eq("run_start_len", start_len, exp_len);
        chk_eq("run_timeout", timeout, exp_to);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not complete, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int sc, mc, d0, n;
        repeat (2) @(negedge clock);
        chk_eq("reset_outputs", {iram_write_ext, dram_write_ext, read_en_ext, start, start_2,
               start_3, start_4, done, err_core, timeout, rd_valid, wr_ready}, 0);
        chk_eq("reset_addr", addr_ext, 0);
        chk_eq("reset_cmd_ready", cmd_ready, 1);
        reset = 1'b0;

        // IRAM load to core 1, three words from address 1
        wlog_addr.delete(); wlog_data.delete(); wlog_vec.delete();
        do_load(2'd0, 1, 1, 3, 10, 20, 30);
        chk_eq("iram_log_size", wlog_addr.size(), 3);
        chk_eq("iram_addr0", wlog_addr[0], 1);
        chk_eq("iram_addr2", wlog_addr[2], 3);
        chk_eq("iram_data1", wlog_data[1], 20);
        chk_eq("iram_vec0", wlog_vec[0], 4'b0010);

        // DRAM load across the address wrap
        wlog_addr.delete(); wlog_data.delete(); wlog_vec.delete();
        do_load(2'd1, 0, 511, 2, 16'h1111, 16'h2222, 0);
        chk_eq("dram_addr0", wlog_addr[0], 511);
        chk_eq("dram_addr1", wlog_addr[1], 0);
        chk_eq("dram_vec", wlog_vec[1], 4'b1000);

        run_cmd(50, 50, 0);

        // proc_done outside RUN must not produce completion
        d0 = done_cnt;
        @(negedge clock); proc_done = 1'b1;
        repeat (3) @(negedge clock);
        proc_done = 1'b0;
        @(negedge clock);
        chk_eq("proc_done_idle_ignored", done_cnt - d0, 0);

        run_cmd(0, 100, 1);

        // Readback with first word backpressured
        rq.delete(); rlog.delete();
        rq.push_back(24); rq.push_back(27);
        rd_en_cycles = 0;
        rd_ready = 1'b0;
        send_cmd(2'd3, 0, 8, 2);
        n = 0;
        while (!rd_valid && n < 50) begin @(negedge clock); n++; end
        chk_eq("rb_first_valid", rd_valid, 1);
        repeat (5) @(negedge clock);
        rd_ready = 1'b1;
        wait_done("rb", 100);
        @(negedge clock);
        rd_ready = 1'b0;
        chk_eq("rb_log_size", rlog.size(), 2);
        chk_eq("rb_word0", rlog[0], 24);
        chk_eq("rb_word1", rlog[1], 27);
        chk_eq("rb_read_en_cycles", rd_en_cycles, 10);

        // Bad core, then empty load and empty readback
        sc = strobe_cycles; mc = mode_cycles; d0 = done_cnt;
        send_cmd(2'd0, 3, 0, 1);
        chk_eq("err_done_next", done, 1);
        chk_eq("err_core_set", err_core, 1);
        send_cmd(2'd1, 0, 0, 0);
        chk_eq("zero_done_next", done, 1);
        chk_eq("err_core_cleared", err_core, 0);
        send_cmd(2'd3, 0, 4, 0);
        chk_eq("zero_rb_done_next", done, 1);
        @(negedge clock);
        chk_eq("err_zero_no_strobe", strobe_cycles - sc, 0);
        chk_eq("err_zero_no_mode", mode_cycles - mc, 0);
        chk_eq("err_zero_done_count", done_cnt - d0, 3);

        // Reset in the middle of a strobe
        wlog_addr.delete(); wlog_data.delete(); wlog_vec.delete();
        send_cmd(2'd1, 0, 5, 2);
        n = 0;
        while (!wr_ready && n < 50) begin @(negedge clock); n++; end
        wr_valid = 1'b1; wr_data = 16'hBEEF;
        @(negedge clock);
        wr_valid = 1'b0;
        n = 0;
        while (!dram_write_ext && n < 20) begin @(negedge clock); n++; end
        chk_eq("mid_strobe_reached", dram_write_ext, 1);
        #1 reset = 1'b1;
        #1;
        chk_eq("mid_reset_pins", {iram_write_ext, dram_write_ext, read_en_ext,
               start, start_2, start_3, start_4, rd_valid, wr_ready}, 0);
        chk_eq("mid_reset_addr", addr_ext, 0);
        chk_eq("mid_reset_data", data_out, 0);
        wq_addr.delete(); wq_data.delete(); wq_vec.delete();
        repeat (2) @(negedge clock);
        reset = 1'b0;
        @(negedge clock);
        chk_eq("post_reset_ready", cmd_ready, 1);
        chk_eq("no_partial_write", wlog_addr.size(), 0);
        do_load(2'd1, 0, 5, 1, 16'h1234, 0, 0);
        chk_eq("post_reset_addr", wlog_addr[0], 5);
        chk_eq("post_reset_data", wlog_data[0], 16'h1234);

        repeat (3) @(negedge clock);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
